mult_seq_ctrl: RTL and testbench

Parametrised sequential shift-add multiplier with its own control FSM and FIFO handshakes. It pops operand pairs from a first-word-fall-through input FIFO and computes each WIDTH x WIDTH product over WIDTH cycles. Each 2*WIDTH-bit result is pushed to an output FIFO. A batch runs until the input FIFO drains, then the block holds op_done. It is the next generation of the multiplier top's IDLE/EXEC/OUT/DONE control and output logic, adding generic width, a signed mode, output backpressure and abort.

---
 rtl/mult_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequential shift-add multiplier with FIFO handshake control
// One multiplier bit per EXEC cycle; signed mode subtracts the MSB partial product.
module mult_seq_ctrl #(
   parameter int WIDTH   = 16,
   parameter int CNT_W   = 4,
   parameter int OPCNT_W = 8,
   parameter int SIGNED  = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 op_start,
   input  logic                 op_clear,
   input  logic                 in_empty,
   input  logic [WIDTH-1:0]     in_data_a,
   input  logic [WIDTH-1:0]     in_data_b,
   output logic                 in_rd,
   input  logic                 out_full,
   output logic                 out_wr,
   output logic [2*WIDTH-1:0]   out_data,
   output logic                 op_done,
   output logic                 busy,
   output logic [1:0]           state,
   output logic [CNT_W-1:0]     count,
   output logic [OPCNT_W-1:0]   op_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_OUT  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   state_t               state_r, state_nx;
   logic [2*WIDTH-1:0]   a_sh, acc, addend, acc_nx, a_ext;
   logic [WIDTH-1:0]     b_sh;
   logic                 last_step;

   assign a_ext     = {{WIDTH{(SIGNED != 0) & in_data_a[WIDTH-1]}}, in_data_a};
   assign last_step = (count == CNT_W'(WIDTH - 1));

   // In signed mode the multiplier MSB carries weight -2**(WIDTH-1), so its term is subtracted.
   always_comb begin
      addend = '0;
      if (b_sh[0])
         addend = ((SIGNED != 0) && last_step) ? ('0 - a_sh) : a_sh;
      acc_nx = acc + addend;
   end

   always_comb begin
      state_nx = state_r;
      in_rd    = 1'b0;
      out_wr   = 1'b0;
      if (op_clear) begin
         state_nx = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (op_start) begin
                  if (!in_empty) begin
                     in_rd    = 1'b1;
                     state_nx = S_EXEC;
                  end else begin
                     state_nx = S_DONE;
                  end
               end
            end
            S_EXEC: begin
               if (last_step)
                  state_nx = S_OUT;
            end
            S_OUT: begin
               if (!out_full) begin
                  out_wr = 1'b1;
                  if (!in_empty) begin
                     in_rd    = 1'b1;
                     state_nx = S_EXEC;
                  end else begin
                     state_nx = S_DONE;
                  end
               end
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= S_IDLE;
         count    <= '0;
         out_data <= '0;
         op_cnt   <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         acc      <= '0;
      end else begin
         state_r <= state_nx;
         if (op_clear) begin
            count <= '0;
         end else begin
            if (state_r == S_IDLE && op_start)
               op_cnt <= '0;
            if (out_wr)
               op_cnt <= op_cnt + OPCNT_W'(1);
            // A pop always starts a fresh product, whether from IDLE or chained from OUT.
            if (in_rd) begin
               a_sh  <= a_ext;
               b_sh  <= in_data_b;
               acc   <= '0;
               count <= '0;
            end else if (state_r == S_EXEC) begin
               a_sh <= a_sh << 1;
               b_sh <= b_sh >> 1;
               acc  <= acc_nx;
               if (last_step) begin
                  out_data <= acc_nx;
                  count    <= '0;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
         end
      end
   end

   assign state   = state_r;
   assign busy    = (state_r == S_EXEC) || (state_r == S_OUT);
   assign op_done = (state_r == S_DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - scoreboard bench for mult_seq_ctrl, unsigned and signed instances
// Both instances share one FIFO model and run in lockstep; each has its own expected queue.
module tb_mult_seq_ctrl;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          op_start = 1'b0, op_clear = 1'b0, out_full = 1'b0;
   logic          in_empty = 1'b1;
   logic [W-1:0]  in_a = '0, in_b = '0;

   logic          rd_u, wr_u, done_u, busy_u, rd_s, wr_s, done_s, busy_s;
   logic [2*W-1:0] out_u, out_s;
   logic [1:0]    st_u, st_s;
   logic [3:0]    cnt_u, cnt_s;
   logic [7:0]    opc_u, opc_s;

   mult_seq_ctrl #(.WIDTH(W), .CNT_W(4), .OPCNT_W(8), .SIGNED(0)) u_dut_u (
      .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
      .in_empty(in_empty), .in_data_a(in_a), .in_data_b(in_b), .in_rd(rd_u),
      .out_full(out_full), .out_wr(wr_u), .out_data(out_u), .op_done(done_u),
      .busy(busy_u), .state(st_u), .count(cnt_u), .op_cnt(opc_u));

   mult_seq_ctrl #(.WIDTH(W), .CNT_W(4), .OPCNT_W(8), .SIGNED(1)) u_dut_s (
      .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
      .in_empty(in_empty), .in_data_a(in_a), .in_data_b(in_b), .in_rd(rd_s),
      .out_full(out_full), .out_wr(wr_s), .out_data(out_s), .op_done(done_s),
      .busy(busy_s), .state(st_s), .count(cnt_s), .op_cnt(opc_s));

   always #5 clk = ~clk;

   int tests = 0, failed = 0;
   int cyc = 0, last_rd_cyc = 0, rd_total = 0, wr_total = 0, b2b_hits = 0;
   bit pop_pending = 0;
   logic [W-1:0]   fifo_a[$], fifo_b[$];
   logic [2*W-1:0] exp_u[$], exp_s[$];
   int             exp_lat[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic refresh();
      in_empty = (fifo_a.size() == 0);
      in_a     = in_empty ? '0 : fifo_a[0];
      in_b     = in_empty ? '0 : fifo_b[0];
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_out,
                       input logic [2*W-1:0] eu, input logic [2*W-1:0] es, input int lat);
      fifo_a.push_back(a);
      fifo_b.push_back(b);
      if (expect_out) begin
         exp_u.push_back(eu);
         exp_s.push_back(es);
         exp_lat.push_back(lat);
      end
      refresh();
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_state(input logic [1:0] st, input int budget, input string name);
      int n = 0;
      while (st_u !== st && n < budget) begin
         tick();
         n++;
      end
      chk(name, st_u, st);
   endtask

   task automatic start_batch();
      op_start = 1'b1;
      tick();
      op_start = 1'b0;
   endtask

   task automatic clear_batch();
      op_clear = 1'b1;
      tick();
      op_clear = 1'b0;
   endtask

   // Monitor: samples mid-cycle, checks protocol and pops the scoreboard on every push.
   always @(negedge clk) begin
      cyc++;
      if (reset_n) begin
         if (rd_u !== rd_s || wr_u !== wr_s) begin
            tests++; failed++;
            $display("FAIL lockstep: rd %b/%b wr %b/%b required equal", rd_u, rd_s, wr_u, wr_s);
         end
         if (rd_u && in_empty) begin
            tests++; failed++;
            $display("FAIL rd_when_empty: in_rd=1 required 0");
         end
         if (wr_u && out_full) begin
            tests++; failed++;
            $display("FAIL wr_when_full: out_wr=1 required 0");
         end
         if (wr_u) begin
            wr_total++;
            if (exp_u.size() == 0) begin
               tests++; failed++;
               $display("FAIL unexpected_wr: out_data=0x%0h required no write", out_u);
            end else begin
               automatic logic [2*W-1:0] eu = exp_u.pop_front();
               automatic logic [2*W-1:0] es = exp_s.pop_front();
               automatic int lat = exp_lat.pop_front();
               chk("out_data_unsigned", out_u, eu);
               chk("out_data_signed", out_s, es);
               if (lat != 0) chk("latency", cyc - last_rd_cyc, lat);
               if (rd_u) b2b_hits++;
            end
         end
         if (rd_u) begin
            last_rd_cyc = cyc;
            rd_total++;
            pop_pending = 1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (pop_pending) begin
         pop_pending = 0;
         if (fifo_a.size() != 0) begin
            void'(fifo_a.pop_front());
            void'(fifo_b.pop_front());
         end
         refresh();
      end
   end

   initial begin
      int rd_before, wr_before, n;

      // Reset values
      repeat (3) tick();
      chk("rst_state", st_u, 2'b00);
      chk("rst_count", cnt_u, 0);
      chk("rst_out_data", out_u, 0);
      chk("rst_op_cnt", opc_u, 0);
      chk("rst_flags", {rd_u, wr_u, done_u, busy_u}, 4'b0000);
      reset_n = 1'b1;
      tick();

      // 1: single op (3,5)
      push(16'd3, 16'd5, 1, 32'h0000000F, 32'h0000000F, 17);
      start_batch();
      chk("s1_busy", busy_u, 1'b1);
      wait_state(2'b11, 40, "s1_done_state");
      chk("s1_op_done", done_u, 1'b1);
      chk("s1_busy_low", busy_u, 1'b0);
      chk("s1_op_cnt", opc_u, 1);
      chk("s1_drained", exp_u.size(), 0);
      clear_batch();
      chk("s1_clear_idle", st_u, 2'b00);

      // 2: back-to-back unsigned extremes
      push(16'hFFFF, 16'hFFFF, 1, 32'hFFFE0001, 32'h00000001, 17);
      push(16'h0000, 16'h1234, 1, 32'h00000000, 32'h00000000, 17);
      start_batch();
      wait_state(2'b11, 60, "s2_done_state");
      chk("s2_op_cnt", opc_u, 2);
      chk("s2_b2b", b2b_hits, 1);
      clear_batch();

      // 3: signed corner cases, run through both instances
      push(16'h8000, 16'h7FFF, 1, 32'h3FFF8000, 32'hC0008000, 17);
      push(16'h8000, 16'h8000, 1, 32'h40000000, 32'h40000000, 17);
      push(16'hFFFF, 16'hFFFF, 1, 32'hFFFE0001, 32'h00000001, 17);
      start_batch();
      wait_state(2'b11, 80, "s3_done_state");
      chk("s3_op_cnt", opc_s, 3);
      chk("s3_b2b", b2b_hits, 3);
      clear_batch();

      // 4: output backpressure for 10 cycles
      out_full = 1'b1;
      push(16'hFFFE, 16'h0003, 1, 32'h0002FFFA, 32'hFFFFFFFA, 0);
      start_batch();
      wait_state(2'b10, 40, "s4_reach_out");
      wr_before = wr_total;
      for (int i = 0; i < 10; i++) begin
         chk("s4_hold_state", st_u, 2'b10);
         chk("s4_hold_data", out_u, 32'h0002FFFA);
         tick();
      end
      chk("s4_no_wr", wr_total, wr_before);
      out_full = 1'b0;
      wait_state(2'b11, 5, "s4_done_state");
      chk("s4_single_wr", wr_total, wr_before + 1);
      chk("s4_op_cnt", opc_u, 1);
      clear_batch();

      // 5: start on empty FIFO, then abort mid-EXEC
      rd_before = rd_total;
      start_batch();
      chk("s5_empty_done", st_u, 2'b11);
      chk("s5_empty_op_cnt", opc_u, 0);
      chk("s5_no_rd", rd_total, rd_before);
      clear_batch();
      push(16'h1111, 16'h2222, 0, '0, '0, 0);
      push(16'h3333, 16'h4444, 0, '0, '0, 0);
      wr_before = wr_total;
      start_batch();
      n = 0;
      while (!(st_u == 2'b01 && cnt_u == 4'd7) && n < 50) begin
         tick();
         n++;
      end
      chk("s5_reach_cnt7", cnt_u, 7);
      clear_batch();
      chk("s5_abort_idle", st_u, 2'b00);
      chk("s5_abort_count", cnt_u, 0);
      repeat (25) tick();
      chk("s5_no_wr", wr_total, wr_before);
      chk("s5_one_pop", fifo_a.size(), 1);
      chk("s5_out_data_kept", out_u, 32'h0002FFFA);
      fifo_a.delete();
      fifo_b.delete();
      refresh();

      // 6: asynchronous reset while stalled in OUT
      out_full = 1'b1;
      push(16'd2, 16'd3, 0, '0, '0, 0);
      start_batch();
      wait_state(2'b10, 40, "s6_reach_out");
      #1 reset_n = 1'b0;
      #1;
      chk("s6_rst_state", st_u, 2'b00);
      chk("s6_rst_out_data", out_u, 0);
      chk("s6_rst_op_cnt", opc_u, 0);
      chk("s6_rst_count", cnt_u, 0);
      chk("s6_rst_flags", {wr_u, done_u, busy_u}, 3'b000);
      out_full = 1'b0;
      repeat (2) tick();
      #3 reset_n = 1'b1;
      tick();
      push(16'd3, 16'd5, 1, 32'h0000000F, 32'h0000000F, 17);
      start_batch();
      wait_state(2'b11, 40, "s6_done_state");
      chk("s6_op_cnt", opc_u, 1);
      chk("s6_op_done", done_u, 1'b1);
      clear_batch();

      tick();
      chk("all_drained", exp_u.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
